// File: rtl/mem_stage.sv
// Memory stage: runs byte-serial loads/stores against the memory arbiter, then registers write-back.
// Latency: non-memory ops 1 cycle; memory ops 1 IDLE cycle plus cycles until the n-th mem_ready, write-back one edge later.
// Backpressure: stall_req holds IF/ID/EX and the EX/MEM latch until the last byte is acknowledged.
//
// Ports:
//   clk, rst                  - single clock, synchronous active-high reset
//   ex_*                      - EX/MEM latch contents, held stable while stall_req=1
//   mem_req/rw/addr/wdata     - one byte transfer per request towards the arbiter
//   mem_rdata, mem_ready      - returned load byte and one-cycle completion pulse
//   stall_req                 - combinational pipeline hold
//   w_enable/w_addr/w_data    - registered write-back to the register file
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_wreg,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_store_data,
    output logic        mem_req,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        stall_req,
    output logic        w_enable,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] buf_q, buf_d;
    logic        w_enable_q, w_enable_d;
    logic [4:0]  w_addr_q, w_addr_d;
    logic [31:0] w_data_q, w_data_d;

    // Op decode
    logic        is_load;
    logic        is_store;
    logic        memop;
    logic [1:0]  last_idx;
    logic        last;
    logic        active;
    logic        retire;
    logic [31:0] load_res;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        last_idx = 2'd0;
        case (ex_mem_op)
            OP_LB, OP_LBU: begin is_load  = 1'b1; last_idx = 2'd0; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; last_idx = 2'd1; end
            OP_LW:         begin is_load  = 1'b1; last_idx = 2'd3; end
            OP_SB:         begin is_store = 1'b1; last_idx = 2'd0; end
            OP_SH:         begin is_store = 1'b1; last_idx = 2'd1; end
            OP_SW:         begin is_store = 1'b1; last_idx = 2'd3; end
            default:       begin is_load  = 1'b0; is_store = 1'b0; last_idx = 2'd0; end
        endcase
        memop  = is_load | is_store;
        last   = (cnt_q == last_idx);
        active = ex_valid & memop;
        retire = active & (state_q == S_XFER) & mem_ready & last;
    end

    // Pipeline hold and arbiter-facing outputs; reset overrides both requests
    always_comb begin
        stall_req = ~rst & active & ~retire;
        mem_req   = ~rst & (state_q == S_XFER);
        mem_rw    = (state_q == S_XFER) & is_store;
        mem_addr  = ex_mem_addr + {30'd0, cnt_q};
        case (cnt_q)
            2'd0:    mem_wdata = ex_store_data[7:0];
            2'd1:    mem_wdata = ex_store_data[15:8];
            2'd2:    mem_wdata = ex_store_data[23:16];
            default: mem_wdata = ex_store_data[31:24];
        endcase
    end

    // The final byte comes straight from mem_rdata so the result is ready on the retiring edge
    always_comb begin
        case (ex_mem_op)
            OP_LB:   load_res = {{24{mem_rdata[7]}}, mem_rdata};
            OP_LBU:  load_res = {24'd0, mem_rdata};
            OP_LH:   load_res = {{16{mem_rdata[7]}}, mem_rdata, buf_q[7:0]};
            OP_LHU:  load_res = {16'd0, mem_rdata, buf_q[7:0]};
            OP_LW:   load_res = {mem_rdata, buf_q};
            default: load_res = 32'd0;
        endcase
    end

    // Transfer FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (active) begin
                    state_d = S_XFER;
                    cnt_d   = 2'd0;
                end
            end
            S_XFER: begin
                if (!active) begin
                    // EX/MEM contents changed under us; drop back rather than run a stale access
                    state_d = S_IDLE;
                    cnt_d   = 2'd0;
                end else if (mem_ready) begin
                    if (last) begin
                        state_d = S_IDLE;
                        cnt_d   = 2'd0;
                    end else begin
                        if (is_load) begin
                            case (cnt_q)
                                2'd0:    buf_d[7:0]   = mem_rdata;
                                2'd1:    buf_d[15:8]  = mem_rdata;
                                default: buf_d[23:16] = mem_rdata;
                            endcase
                        end
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Write-back next state; address/data hold unless something retires
    always_comb begin
        w_enable_d = 1'b0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        if (retire && is_load) begin
            w_enable_d = ex_wreg;
            w_addr_d   = ex_waddr;
            w_data_d   = load_res;
        end else if (ex_valid && !memop && !stall_req) begin
            w_enable_d = ex_wreg;
            w_addr_d   = ex_waddr;
            w_data_d   = ex_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            buf_q      <= 24'd0;
            w_enable_q <= 1'b0;
            w_addr_q   <= 5'd0;
            w_data_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            w_enable_q <= w_enable_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
        end
    end

    assign w_enable = w_enable_q;
    assign w_addr   = w_addr_q;
    assign w_data   = w_data_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_wreg;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic        mem_req;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        stall_req;
    logic        w_enable;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_wreg       (ex_wreg),
        .ex_waddr      (ex_waddr),
        .ex_wdata      (ex_wdata),
        .ex_mem_op     (ex_mem_op),
        .ex_mem_addr   (ex_mem_addr),
        .ex_store_data (ex_store_data),
        .mem_req       (mem_req),
        .mem_rw        (mem_rw),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .stall_req     (stall_req),
        .w_enable      (w_enable),
        .w_addr        (w_addr),
        .w_data        (w_data)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: byte-addressed memory plus the last written-back register values
    logic [7:0]  mem_model [logic [31:0]];
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic int op_len(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd6: return 1;
            4'd2, 4'd5, 4'd7: return 2;
            4'd3, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic logic [31:0] load_value(input logic [3:0] op, input logic [31:0] raw);
        case (op)
            4'd1:    return {{24{raw[7]}}, raw[7:0]};
            4'd2:    return {{16{raw[15]}}, raw[15:0]};
            4'd3:    return raw;
            4'd4:    return {24'd0, raw[7:0]};
            4'd5:    return {16'd0, raw[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    // Runs one memory op acting as the arbiter; returns at the negedge after retirement
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic wreg, input logic [4:0] waddr, input int max_gap, input string tag);
        int          n;
        int          gap;
        logic [31:0] raw;
        logic [31:0] a;
        logic [7:0]  sbyte;
        logic        exp_en;
        logic        exp_stall;
        n = op_len(op);
        ex_valid      = 1'b1;
        ex_wreg       = wreg;
        ex_waddr      = waddr;
        ex_wdata      = $urandom;
        ex_mem_op     = op;
        ex_mem_addr   = addr;
        ex_store_data = sdata;
        mem_ready     = 1'b0;
        mem_rdata     = 8'($urandom);
        #1;
        total++;
        if (stall_req !== 1'b1 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_cycle: stall_req=%b mem_req=%b, want 1 0", tag, stall_req, mem_req);
        end
        raw = 32'd0;
        for (int k = 0; k < n; k++) begin
            a   = addr + 32'(k);
            gap = $urandom_range(max_gap, 0);
            for (int g = 0; g <= gap; g++) begin
                @(negedge clk);
                mem_ready = (g == gap);
                mem_rdata = (g == gap) ? mem_byte(a) : 8'($urandom);
                #1;
                exp_stall = (g != gap) || (k != n - 1);
                total++;
                if (mem_req !== 1'b1 || mem_addr !== a || mem_rw !== op_is_store(op) ||
                    stall_req !== exp_stall || w_enable !== 1'b0) begin
                    bad++;
                    $display("FAIL %s xfer byte%0d: req=%b addr=%h rw=%b stall=%b wen=%b, want 1 %h %b %b 0",
                             tag, k, mem_req, mem_addr, mem_rw, stall_req, w_enable,
                             a, op_is_store(op), exp_stall);
                end
                if (g == gap) begin
                    if (op_is_store(op)) begin
                        sbyte = 8'(sdata >> (8 * k));
                        total++;
                        if (mem_wdata !== sbyte) begin
                            bad++;
                            $display("FAIL %s store byte%0d: wdata=%h, want %h", tag, k, mem_wdata, sbyte);
                        end
                        mem_model[a] = mem_wdata;
                    end else begin
                        raw = raw | (32'(mem_byte(a)) << (8 * k));
                    end
                end
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        if (op_is_store(op)) begin
            exp_en = 1'b0;
        end else begin
            exp_en    = wreg;
            exp_waddr = waddr;
            exp_wdata = load_value(op, raw);
        end
        total++;
        if (w_enable !== exp_en || w_addr !== exp_waddr || w_data !== exp_wdata || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL %s retire: wen=%b waddr=%0d wdata=%h req=%b, want %b %0d %h 0",
                     tag, w_enable, w_addr, w_data, mem_req, exp_en, exp_waddr, exp_wdata);
        end
    endtask

    task automatic do_alu(input logic [3:0] op, input logic wreg, input logic [4:0] waddr,
                          input logic [31:0] wdata, input string tag);
        ex_valid      = 1'b1;
        ex_wreg       = wreg;
        ex_waddr      = waddr;
        ex_wdata      = wdata;
        ex_mem_op     = op;
        ex_mem_addr   = $urandom;
        ex_store_data = $urandom;
        mem_ready     = 1'($urandom);
        mem_rdata     = 8'($urandom);
        #1;
        total++;
        if (stall_req !== 1'b0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL %s alu_stall: stall_req=%b mem_req=%b, want 0 0", tag, stall_req, mem_req);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        exp_waddr = waddr;
        exp_wdata = wdata;
        total++;
        if (w_enable !== wreg || w_addr !== exp_waddr || w_data !== exp_wdata) begin
            bad++;
            $display("FAIL %s alu_wb: wen=%b waddr=%0d wdata=%h, want %b %0d %h",
                     tag, w_enable, w_addr, w_data, wreg, exp_waddr, exp_wdata);
        end
    endtask

    task automatic idle_cycle(input string tag);
        ex_valid  = 1'b0;
        ex_mem_op = 4'($urandom);
        mem_ready = 1'($urandom);
        #1;
        total++;
        if (stall_req !== 1'b0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_outputs: stall_req=%b mem_req=%b, want 0 0", tag, stall_req, mem_req);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        total++;
        if (w_enable !== 1'b0 || w_addr !== exp_waddr || w_data !== exp_wdata) begin
            bad++;
            $display("FAIL %s idle_hold: wen=%b waddr=%0d wdata=%h, want 0 %0d %h",
                     tag, w_enable, w_addr, w_data, exp_waddr, exp_wdata);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        ex_valid      = 1'b1;
        ex_wreg       = 1'b1;
        ex_waddr      = 5'd9;
        ex_wdata      = 32'hDEADBEEF;
        ex_mem_op     = 4'd3;
        ex_mem_addr   = 32'h100;
        ex_store_data = 32'd0;
        mem_rdata     = 8'd0;
        mem_ready     = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (mem_req !== 1'b0 || stall_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_comb: mem_req=%b stall_req=%b, want 0 0", mem_req, stall_req);
        end
        total++;
        if (w_enable !== 1'b0 || w_addr !== 5'd0 || w_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_regs: wen=%b waddr=%0d wdata=%h, want 0 0 0", w_enable, w_addr, w_data);
        end
        rst       = 1'b0;
        ex_valid  = 1'b0;
        mem_ready = 1'b0;
        exp_waddr = 5'd0;
        exp_wdata = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        do_alu(4'd0, 1'b1, 5'd5, 32'h00001234, "pass");
        total++;
        if (w_data !== 32'h00001234) begin
            bad++;
            $display("FAIL pass_value: w_data=%h, want 00001234", w_data);
        end
        do_alu(4'd12, 1'b1, 5'd0, 32'hCAFEF00D, "pass_x0_op12");
        idle_cycle("pass_idle");
    endtask

    task automatic test_lw_gaps();
        mem_model[32'h2000] = 8'h78;
        mem_model[32'h2001] = 8'h56;
        mem_model[32'h2002] = 8'h34;
        mem_model[32'h2003] = 8'h12;
        do_op(4'd3, 32'h2000, 32'd0, 1'b1, 5'd7, 3, "lw");
        total++;
        if (w_data !== 32'h12345678) begin
            bad++;
            $display("FAIL lw_value: w_data=%h, want 12345678", w_data);
        end
        idle_cycle("lw_idle");
    endtask

    task automatic test_byte_loads();
        mem_model[32'h1000] = 8'h80;
        do_op(4'd1, 32'h1000, 32'd0, 1'b1, 5'd3, 2, "lb");
        total++;
        if (w_data !== 32'hFFFFFF80) begin
            bad++;
            $display("FAIL lb_value: w_data=%h, want ffffff80", w_data);
        end
        do_op(4'd4, 32'h1000, 32'd0, 1'b1, 5'd4, 2, "lbu");
        total++;
        if (w_data !== 32'h00000080) begin
            bad++;
            $display("FAIL lbu_value: w_data=%h, want 00000080", w_data);
        end
        mem_model[32'h8001] = 8'h01;
        mem_model[32'h8002] = 8'h80;
        do_op(4'd2, 32'h8001, 32'd0, 1'b1, 5'd6, 2, "lh");
        total++;
        if (w_data !== 32'hFFFF8001) begin
            bad++;
            $display("FAIL lh_value: w_data=%h, want ffff8001", w_data);
        end
        idle_cycle("lh_idle");
    endtask

    task automatic test_store();
        do_op(4'd7, 32'h3002, 32'hAABBCCDD, 1'b1, 5'd8, 2, "sh");
        total++;
        if (mem_byte(32'h3002) !== 8'hDD || mem_byte(32'h3003) !== 8'hCC) begin
            bad++;
            $display("FAIL sh_bytes: mem[3002]=%h mem[3003]=%h, want dd cc", mem_byte(32'h3002), mem_byte(32'h3003));
        end
        do_op(4'd8, 32'hFFFFFFFE, 32'h11223344, 1'b1, 5'd8, 1, "sw_wrap");
        do_op(4'd3, 32'hFFFFFFFE, 32'd0, 1'b1, 5'd10, 1, "lw_wrap");
        total++;
        if (w_data !== 32'h11223344) begin
            bad++;
            $display("FAIL wrap_value: w_data=%h, want 11223344", w_data);
        end
        idle_cycle("store_idle");
    endtask

    task automatic test_reset_mid();
        ex_valid      = 1'b1;
        ex_wreg       = 1'b1;
        ex_waddr      = 5'd11;
        ex_mem_op     = 4'd3;
        ex_mem_addr   = 32'h4000;
        ex_store_data = 32'd0;
        mem_ready     = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = 8'h11;
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = 8'h22;
        @(negedge clk);
        mem_ready = 1'b0;
        rst       = 1'b1;
        #1;
        total++;
        if (mem_req !== 1'b0 || stall_req !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_comb: mem_req=%b stall_req=%b, want 0 0", mem_req, stall_req);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_waddr = 5'd0;
        exp_wdata = 32'd0;
        #1;
        total++;
        if (mem_req !== 1'b0 || stall_req !== 1'b1 || w_enable !== 1'b0 || w_addr !== 5'd0 || w_data !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_after: req=%b stall=%b wen=%b waddr=%0d wdata=%h, want 0 1 0 0 0",
                     mem_req, stall_req, w_enable, w_addr, w_data);
        end
        ex_valid = 1'b0;
        @(negedge clk);
        do_op(4'd3, 32'h4000, 32'd0, 1'b1, 5'd12, 2, "rstmid_relw");
        idle_cycle("rstmid_idle");
    endtask

    task automatic test_back_to_back();
        do_op(4'd3, 32'h6000, 32'd0, 1'b1, 5'd1, 1, "b2b_lw");
        do_op(4'd4, 32'h6003, 32'd0, 1'b1, 5'd2, 0, "b2b_lbu");
        do_op(4'd8, 32'h6000, 32'h89ABCDEF, 1'b0, 5'd3, 1, "b2b_sw");
        do_alu(4'd0, 1'b1, 5'd4, 32'h0BADF00D, "b2b_alu");
        do_op(4'd5, 32'h6002, 32'd0, 1'b1, 5'd5, 0, "b2b_lhu");
        total++;
        if (w_data !== 32'h000089AB) begin
            bad++;
            $display("FAIL b2b_lhu_value: w_data=%h, want 000089ab", w_data);
        end
        idle_cycle("b2b_idle");
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] addr;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(15, 0));
            if ($urandom_range(3, 0) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(3, 0));
            else                           addr = 32'h5000 + 32'($urandom_range(63, 0));
            if (op_len(op) != 0)
                do_op(op, addr, $urandom, 1'($urandom), 5'($urandom), 3, "rand_mem");
            else
                do_alu(op, 1'($urandom), 5'($urandom), $urandom, "rand_alu");
            if ($urandom_range(2, 0) == 0) idle_cycle("rand_idle");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_lw_gaps();
        test_byte_loads();
        test_store();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
